fp_pipe_skid_reg: RTL
=====================

FP_PIPE_SKID_REG -- requirements
Module: fp_pipe_skid_reg

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 SHALL have parameter WIDTH, default 122, giving the payload width in bits (the full FP add stage bundle).
REQ-003 SHALL have parameter CNT_W, default 16, giving the stall counter width.
REQ-004 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous reset, asserted low.
REQ-006 SHALL have port flush, input, 1 bit: synchronous discard of all held beats.
REQ-007 SHALL have port in_valid, input, 1 bit: upstream beat present.
REQ-008 SHALL have port in_ready, output, 1 bit: block can accept a beat.
REQ-009 SHALL have port in_data, input, WIDTH bits: upstream payload.
REQ-010 SHALL have port out_valid, output, 1 bit: downstream beat present.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts.
REQ-012 SHALL have port out_data, output, WIDTH bits: downstream payload.
REQ-013 SHALL have port occupancy, output, 2 bits: beats held, 0 to 2.
REQ-014 SHALL have port stall_cnt, output, CNT_W bits, present only with FP_PIPE_PERF_EN: count of cycles with out_valid=1 and out_ready=0.

Function
REQ-015 SHALL hold two slots, MAIN (drives out_*) and SKID, and track state EMPTY, ONE or FULL; occupancy is 0, 1 or 2 respectively.
REQ-016 SHALL transfer a beat on the input when in_valid and in_ready are both 1 at a rising edge, and on the output when out_valid and out_ready are both 1.
REQ-017 SHALL drive in_ready from a register, equal to 1 in EMPTY and ONE and 0 in FULL, with no combinational path from out_ready.
REQ-018 SHALL drive out_valid=1 and out_data=MAIN in ONE and FULL.
REQ-019 SHALL have a latency of 1 cycle, from accepted input to out_valid, when EMPTY.
REQ-020 SHALL make these transitions: EMPTY+in -> ONE; ONE+in+out -> ONE (MAIN reloaded); ONE+in, no out -> FULL (beat to SKID); ONE+out, no in -> EMPTY; FULL+out -> ONE (SKID moves to MAIN); all other cases hold state.
REQ-021 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL preserve beat order; no beat is lost, duplicated or reordered.
REQ-023 SHALL have flush take priority over every transfer: the next state is EMPTY, a beat presented in the flush cycle is discarded, and in_ready returns to 1 in the following cycle.
REQ-024 SHALL leave slot data contents unchanged on flush; only the valid state is cleared.

Reset
REQ-025 SHALL, while rst=0, immediately force: state EMPTY, out_valid=0, in_ready=0, out_data=0, occupancy=0, and stall_cnt=0.
REQ-026 SHALL raise in_ready to 1 on the first rising clk edge after rst deasserts.
REQ-027 SHALL drop any beats in flight on a reset mid-operation; no partial beat appears on out_data.

Configuration
REQ-028 SHALL, with FP_PIPE_PERF_EN defined, implement stall_cnt, incrementing by 1 per stalled cycle and saturating at all-ones; flush does not clear it.
REQ-029 SHALL, without FP_PIPE_PERF_EN, omit the stall_cnt port and its logic, leaving all other behaviour identical.

Structure
REQ-030 SHALL take from shared package fp_pipe_pkg: constant FP_BUNDLE_W=122, the state enum (EMPTY, ONE, FULL), and the occupancy type.
REQ-031 SHALL instantiate sub-module fp_pipe_slot twice (MAIN and SKID); each is a WIDTH-bit register with load enable, async active-low reset to 0.

Verification
REQ-032 SHALL cover: reset release, then in_data=0x1 with in_valid=1 and out_ready=1 -> out_valid=1 and out_data=0x1 one cycle later, occupancy=1.
REQ-033 SHALL cover: out_ready=0, beats 0xA then 0xB -> occupancy=2 and in_ready=0; a 0xC held on input is not accepted; out_ready=1 -> 0xA, 0xB, 0xC in order.
REQ-034 SHALL cover: continuous in_valid=1 and out_ready=1 for 100 beats of incrementing data -> one beat per cycle and in_ready=1 throughout.
REQ-035 SHALL cover: FULL plus flush=1 with in_valid=1 and data 0x5 -> next cycle out_valid=0 and occupancy=0; 0x5 never appears on output.
REQ-036 SHALL cover: rst pulled low asynchronously mid-cycle while FULL -> out_valid=0 and out_data=0 before the next clk edge.
REQ-037 SHALL cover: with FP_PIPE_PERF_EN and CNT_W=4, out_valid=1 with out_ready=0 for 20 cycles -> stall_cnt=15 (saturated).

Source files
------------

// File: rtl/fp_pipe_pkg.sv
// ----------------------------------------------------------------------------
// fp_pipe_pkg
// Shared definitions for the FP pipeline skid register.
//   FP_BUNDLE_W : width of the full FP add stage bundle (default payload width)
//   state_e     : holding state of the skid register (EMPTY, ONE, FULL)
//   occ_t       : occupancy count type, 0..2 beats
//   occ_of()    : maps a holding state to its occupancy count
// ----------------------------------------------------------------------------
package fp_pipe_pkg;

    localparam int FP_BUNDLE_W = 122;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    typedef logic [1:0] occ_t;

    function automatic occ_t occ_of(input state_e state);
        case (state)
            ONE:     return 2'd1;
            FULL:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage : fp_pipe_pkg

// File: rtl/fp_pipe_slot.sv
// ----------------------------------------------------------------------------
// fp_pipe_slot
// One WIDTH-bit payload register with load enable. Used twice by the skid
// register, once as MAIN and once as SKID.
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous reset, active low; clears the slot to 0
//   load      : capture load_data at the next rising edge
//   load_data : value to capture
//   data      : current slot contents
// ----------------------------------------------------------------------------
module fp_pipe_slot
    import fp_pipe_pkg::*;
#(
    parameter int WIDTH = FP_BUNDLE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] data
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        // NOTE: default assigned first so every path drives data_d and no latch is inferred.
        data_d = data_q;
        if (load) begin
            data_d = load_data;
        end
    end

    // NOTE: the payload is reset even though only the valid state matters
    // functionally, because out_data must read 0 while reset is held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
        end else begin
            // NOTE: non-blocking assignment for all sequential state.
            data_q <= data_d;
        end
    end

    assign data = data_q;

endmodule : fp_pipe_slot

// File: rtl/fp_pipe_skid_reg.sv
// ----------------------------------------------------------------------------
// fp_pipe_skid_reg
// Two-entry skid register for the FP add pipeline. MAIN drives the output,
// SKID catches the beat that arrives in the cycle the downstream stalls, so
// in_ready can come straight from a flop with no path from out_ready.
//
// Optional feature: define FP_PIPE_PERF_EN to add the stall_cnt output, a
// saturating count of cycles with out_valid=1 and out_ready=0.
//
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous reset, active low
//   flush     : synchronous discard of all held beats (wins over transfers)
//   in_valid  : upstream beat present
//   in_ready  : block can accept a beat (registered)
//   in_data   : upstream payload
//   out_valid : downstream beat present
//   out_ready : downstream accepts
//   out_data  : downstream payload (MAIN slot)
//   occupancy : beats held, 0..2
//   stall_cnt : (FP_PIPE_PERF_EN only) saturating stalled-cycle count
// ----------------------------------------------------------------------------
module fp_pipe_skid_reg
    import fp_pipe_pkg::*;
#(
    parameter int WIDTH = FP_BUNDLE_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output occ_t             occupancy
`ifdef FP_PIPE_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("fp_pipe_skid_reg: CNT_W must be at least 1");
    end

    state_e           state_q;
    state_e           state_d;
    logic             in_ready_q;
    logic             in_ready_d;
    logic             in_fire;
    logic             out_fire;
    logic             main_load;
    logic             skid_load;
    logic [WIDTH-1:0] main_src;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = in_ready_q;
    assign out_data  = main_data;
    assign occupancy = occ_of(state_q);
    assign in_fire   = in_valid && in_ready_q;
    assign out_fire  = out_valid && out_ready;

    // Next-state and slot load control. Flush only clears the valid state;
    // slot contents are left untouched because neither slot is loaded.
    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        skid_load = 1'b0;
        main_src  = in_data;

        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d   = ONE;
                        main_load = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        // MAIN is consumed and refilled in the same edge.
                        main_load = 1'b1;
                    end else if (in_fire) begin
                        state_d   = FULL;
                        skid_load = 1'b1;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the output can move.
                    if (out_fire) begin
                        state_d   = ONE;
                        main_load = 1'b1;
                        main_src  = skid_data;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end

        // Registered ready: it reflects the state we are about to enter, so
        // the upstream never sees a combinational path from out_ready.
        in_ready_d = (state_d != FULL);
    end

    // in_ready resets low and rises on the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    fp_pipe_slot #(
        .WIDTH (WIDTH)
    ) u_main_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (main_load),
        .load_data (main_src),
        .data      (main_data)
    );

    fp_pipe_slot #(
        .WIDTH (WIDTH)
    ) u_skid_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load),
        .load_data (in_data),
        .data      (skid_data)
    );

`ifdef FP_PIPE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    // Saturating stall counter; flush deliberately leaves it alone.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule : fp_pipe_skid_reg
